// File: rtl/keypad_scanner.sv
// ---------------------------------------------------------------------------
// keypad_scanner
//   Scans a 4x4 active-low matrix keypad (Pmod KYPD) one column at a time.
//   It debounces whole-keypad sweeps, reports each confirmed key as a hex
//   code with a one-cycle strobe, and shifts confirmed digits into a 16-bit
//   entry register.
//
// Ports
//   clk       in   system clock
//   reset     in   synchronous, active-high reset
//   row[3:0]  in   keypad rows, active-low, asynchronous to clk
//   col[3:0]  out  keypad column drive, active-low, one-hot-low
//   clr       in   synchronous clear of value
//   key[3:0]  out  hex code of the last confirmed key
//   key_valid out  one-cycle strobe when a new press is confirmed
//   key_held  out  high while a confirmed key remains pressed (FSM state)
//   value     out  entered digits, most recent digit in [3:0]
//
// Strobe semantics: key_valid is high for exactly one cycle per confirmed
// press, and key holds the new code in that same cycle.  There is no
// back-pressure; a consumer that misses the strobe misses the key.
// ---------------------------------------------------------------------------
module keypad_scanner #(
    parameter int SCAN_DIV       = 100_000,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int WIDTH          = 24
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  row,
    output logic [3:0]  col,
    input  logic        clr,
    output logic [3:0]  key,
    output logic        key_valid,
    output logic        key_held,
    output logic [15:0] value
);

    localparam int              SW         = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [WIDTH-1:0] DWELL_LAST = WIDTH'(SCAN_DIV - 1);
    localparam logic [SW-1:0]    STAB_FULL  = SW'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {
        RES_NONE   = 2'd0,
        RES_SINGLE = 2'd1,
        RES_MULTI  = 2'd2
    } result_e;

    typedef enum logic {
        RELEASED = 1'b0,
        PRESSED  = 1'b1
    } state_e;

    // Row/column position to hex code.
    function automatic logic [3:0] keymap(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        case ({r, c})
            4'h0: code = 4'h1;
            4'h1: code = 4'h2;
            4'h2: code = 4'h3;
            4'h3: code = 4'hA;
            4'h4: code = 4'h4;
            4'h5: code = 4'h5;
            4'h6: code = 4'h6;
            4'h7: code = 4'hB;
            4'h8: code = 4'h7;
            4'h9: code = 4'h8;
            4'hA: code = 4'h9;
            4'hB: code = 4'hC;
            4'hC: code = 4'h0;
            4'hD: code = 4'hF;
            4'hE: code = 4'hE;
            default: code = 4'hD;
        endcase
        return code;
    endfunction

    // Registers
    logic [3:0]       row_meta_q, row_s_q;
    logic [WIDTH-1:0] dwell_q, dwell_d;
    logic [1:0]       idx_q, idx_d;
    logic [11:0]      acc_q, acc_d;        // pressed bits of columns 0..2, bit c*4+r
    result_e          prev_kind_q, prev_kind_d;
    logic [3:0]       prev_code_q, prev_code_d;
    logic [SW-1:0]    stab_q, stab_d;
    state_e           state_q, state_d;
    logic [3:0]       key_q, key_d;
    logic             key_valid_q, key_valid_d;
    logic [15:0]      value_q, value_d;

    // Combinational helpers
    logic             sample;
    logic             eval;
    logic [15:0]      sweep_v;
    logic [4:0]       n_low;
    logic [1:0]       hit_r, hit_c;
    result_e          res_kind;
    logic [3:0]       res_code;
    logic             press_evt;

    assign sample = (dwell_q == DWELL_LAST);
    assign eval   = sample && (idx_q == 2'd3);

    // Classify the sweep: the current column 3 sample completes the picture.
    always_comb begin
        sweep_v = {~row_s_q, acc_q};
        n_low   = 5'd0;
        hit_r   = 2'd0;
        hit_c   = 2'd0;
        for (int i = 0; i < 16; i++) begin
            if (sweep_v[i]) begin
                n_low = n_low + 5'd1;
                hit_c = 2'(i >> 2);
                hit_r = 2'(i & 3);
            end
        end
        res_kind = RES_NONE;
        res_code = 4'h0;
        if (n_low == 5'd1) begin
            res_kind = RES_SINGLE;
            res_code = keymap(hit_r, hit_c);
        end else if (n_low != 5'd0) begin
            res_kind = RES_MULTI;
        end
    end

    // Datapath next-state
    always_comb begin
        dwell_d     = dwell_q;
        idx_d       = idx_q;
        acc_d       = acc_q;
        prev_kind_d = prev_kind_q;
        prev_code_d = prev_code_q;
        stab_d      = stab_q;

        if (sample) begin
            dwell_d = '0;
            idx_d   = idx_q + 2'd1;
            case (idx_q)
                2'd0:    acc_d[3:0]  = ~row_s_q;
                2'd1:    acc_d[7:4]  = ~row_s_q;
                2'd2:    acc_d[11:8] = ~row_s_q;
                default: acc_d       = acc_q;
            endcase
        end else begin
            dwell_d = dwell_q + WIDTH'(1);
        end

        // Non-SINGLE results carry code 0, so a plain compare covers both.
        if (eval) begin
            prev_kind_d = res_kind;
            prev_code_d = res_code;
            if (res_kind == prev_kind_q && res_code == prev_code_q) begin
                stab_d = (stab_q == STAB_FULL) ? stab_q : stab_q + SW'(1);
            end else begin
                stab_d = SW'(1);
            end
        end

        key_d       = press_evt ? res_code : key_q;
        key_valid_d = press_evt;

        // The digit enters value at the edge that ends the strobe cycle, so a
        // clr raised during the strobe overrides it.
        if (clr) begin
            value_d = 16'h0000;
        end else if (key_valid_q) begin
            value_d = {value_q[11:0], key_q};
        end else begin
            value_d = value_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            row_meta_q  <= 4'h0;
            row_s_q     <= 4'h0;
            dwell_q     <= '0;
            idx_q       <= 2'd0;
            acc_q       <= 12'h000;
            prev_kind_q <= RES_NONE;
            prev_code_q <= 4'h0;
            stab_q      <= '0;
            key_q       <= 4'h0;
            key_valid_q <= 1'b0;
            value_q     <= 16'h0000;
        end else begin
            row_meta_q  <= row;
            row_s_q     <= row_meta_q;
            dwell_q     <= dwell_d;
            idx_q       <= idx_d;
            acc_q       <= acc_d;
            prev_kind_q <= prev_kind_d;
            prev_code_q <= prev_code_d;
            stab_q      <= stab_d;
            key_q       <= key_d;
            key_valid_q <= key_valid_d;
            value_q     <= value_d;
        end
    end

    // FSM: state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RELEASED;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state.  Only a debounced result at sweep end moves it.
    always_comb begin
        state_d = state_q;
        if (eval && stab_d == STAB_FULL) begin
            case (state_q)
                RELEASED: if (res_kind == RES_SINGLE) state_d = PRESSED;
                default:  if (res_kind == RES_NONE)   state_d = RELEASED;
            endcase
        end
    end

    // FSM: outputs.  key_held is the state itself.
    always_comb begin
        key_held  = (state_q == PRESSED);
        press_evt = (state_q == RELEASED) && (state_d == PRESSED);
    end

    assign col       = ~(4'b0001 << idx_q);
    assign key       = key_q;
    assign key_valid = key_valid_q;
    assign value     = value_q;

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Input-side counterpart of the multiplexed 7-segment display driver. The display driver scans anodes to push data out; this block scans the columns of a 4x4 matrix keypad (Pmod KYPD) to bring data in.
- It debounces key presses and reports each confirmed key as a 4-bit hex code with a one-cycle strobe.
- It shifts the confirmed digits into a 16-bit entry register that the top level can route to the display or into the counter's limit.

Parameters:
- SCAN_DIV, 100_000, clk cycles each column is driven (1 ms at 100 MHz); must be >= 4.
- DEBOUNCE_SCANS, 4, consecutive identical full sweeps required to confirm a press or a release; must be >= 1.
- WIDTH, 24, width of the dwell counter; must hold SCAN_DIV-1.

Ports:
- clk  input  1  system clock, 100 MHz
- reset  input  1  synchronous, active-high reset
- row  input  4  keypad rows, active-low (pulled up externally), asynchronous to clk
- col  output  4  keypad column drive, active-low, exactly one bit low at any time
- clr  input  1  synchronous clear of value
- key  output  4  hex code of the last confirmed key
- key_valid  output  1  one-cycle pulse when a new press is confirmed
- key_held  output  1  high while a confirmed key remains pressed
- value  output  16  entered digits, most recent digit in [3:0]

Behaviour:
- Reset values, held while reset=1:
  - col=4'b1110 (column 0 driven), key=0, key_valid=0, key_held=0, value=0.
  - Dwell counter, column index, synchronizer, sweep accumulator and stability counter all cleared.
  - State=RELEASED.
- Synchronizer: row passes through 2 flops (row_s) before any use.
- Column scan:
  - The dwell counter counts 0..SCAN_DIV-1.
  - When dwell=SCAN_DIV-1, row_s is sampled for the current column, then the column index advances 0->1->2->3->0.
  - col = ~(4'b0001 << index).
  - One sweep = 4*SCAN_DIV cycles.
- Sweep evaluation happens in the cycle column 3 is sampled. The result is one of:
  - NONE: no row low in any column.
  - SINGLE(code): exactly one (row, col) low.
  - MULTI: more than one low.
- Keymap, row r / col c:
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: 0 F E D
- Stability counter:
  - Increments when the sweep result equals the previous sweep result (result type and code both equal).
  - Otherwise reloads to 1.
  - Saturates at DEBOUNCE_SCANS.
- State machine:
  - RELEASED -> PRESSED when the result is SINGLE(code) and the counter reaches DEBOUNCE_SCANS. In the next cycle: key<=code, key_valid=1 for exactly one cycle, key_held<=1, value shifts.
  - PRESSED -> RELEASED when the result is NONE and the counter reaches DEBOUNCE_SCANS. key_held<=0 next cycle; key retains its last code.
  - In PRESSED, a SINGLE result with a different code or a MULTI result causes no event. No new press is reported until a debounced release.
  - In RELEASED, MULTI never confirms. MULTI also resets stability tracking for the next SINGLE.
- Latency: first strobe at most DEBOUNCE_SCANS+1 sweeps + 3 cycles after rows settle.
- Value register:
  - On key_valid: value <= {value[11:0], key_new}.
  - On clr: value <= 0.
  - clr and key_valid in the same cycle: clr wins, value=0. The key and key_valid outputs still report normally.
- Reset mid-press: all state is cleared. A key still held after reset must re-debounce from RELEASED and then produces one strobe.

Test Plan:
1. SCAN_DIV=4, DEBOUNCE_SCANS=2; hold key '5' (r1,c1) for 5 sweeps -> exactly one key_valid pulse, key=4'h5, value=16'h0005, key_held=1; after release for 3 sweeps key_held=0 and key stays 5.
2. Press and release 1,2,3,4,5 in sequence -> five key_valid pulses; final value=16'h2345.
3. Toggle 'A' pressed/released on alternate sweeps for 6 sweeps -> no key_valid pulse, key_held=0.
4. Hold '1' and '9' together for 5 sweeps -> no pulse. Then release '9' -> after the debounce sweeps, one pulse with key=4'h1.
5. Assert reset while 'D' is held and key_held=1 -> outputs return to reset values the next cycle; after deassert, one new pulse with key=4'hD.
6. With value=16'h00AB, assert clr in the same cycle as the key_valid pulse for '7' -> value=0, key=4'h7, key_valid=1. A following press of '3' gives value=16'h0003.
